// File: rtl/sequenciador_principal_pkg.sv
// Package pacote_principal
// Shared types and constants for the step sequencer:
//   codigo_t      - 2-bit state code {e1,e0}
//   estado_fsm_t  - control FSM states
//   SEG_xx        - 7-segment patterns {a,b,c,d,e,f,g} for each code
//   seg_de_codigo - maps a code to its display pattern
package pacote_principal;

  typedef logic [1:0] codigo_t;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    AMOSTRA  = 2'd1,
    APLICA   = 2'd2,
    CONFIRMA = 2'd3
  } estado_fsm_t;

  localparam logic [6:0] SEG_00 = 7'b0001100;
  localparam logic [6:0] SEG_01 = 7'b1111010;
  localparam logic [6:0] SEG_10 = 7'b1111100;
  localparam logic [6:0] SEG_11 = 7'b1110011;

  function automatic logic [6:0] seg_de_codigo(input codigo_t c);
    logic [6:0] s;
    case (c)
      2'b00:   s = SEG_00;
      2'b01:   s = SEG_01;
      2'b10:   s = SEG_10;
      default: s = SEG_11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sequenciador_principal_logica_proximo_estado.sv
// Module logica_proximo_estado
// Purely combinational next-code function.
// Ports:
//   e [1:0] - current code {e1,e0}
//   p [3:0] - sampled debounced pushbuttons {p3,p2,p1,p0}
//   y [1:0] - next code {y1,y0}
module logica_proximo_estado
  import pacote_principal::*;
(
  input  codigo_t    e,
  input  logic [3:0] p,
  output codigo_t    y
);

  assign y[1] = e[1] | (~e[0] & p[3]) | (p[2] & p[1] & ~p[0]) | (p[2] & p[0] & ~p[3]);
  assign y[0] = (e[1] & ~p[3]) | (e[1] & ~p[2]) | (e[1] & p[1] & p[0])
              | (~e[1] & e[0]) | (~e[1] & p[3]);

endmodule

// File: rtl/sequenciador_principal.sv
// Module sequenciador_principal
// Step sequencer: a 2-bit code advances one step at a time, either on a
// manual 4-phase request/acknowledge handshake or on an automatic tick
// every AUTO_DIV cycles. Each step samples the pushbuttons, applies the
// next-code function and refreshes a registered 7-segment display.
// Optional pushbutton debouncing is built when SEQUENCIADOR_DEBOUNCE_EN
// is defined; otherwise the synchronized buttons are used directly.
// Ports:
//   clk        - clock, all registers on rising edge
//   rst_n      - asynchronous active-low reset
//   p_in[3:0]  - pushbuttons p3..p0 (asynchronous)
//   passo_req  - manual step request level (asynchronous)
//   modo       - 0 manual, 1 automatic stepping (asynchronous)
//   passo_ack  - manual step done, held until passo_req seen low
//   ocupado    - FSM not idle
//   estado     - current code {e1,e0}
//   seg        - display pattern {a,b,c,d,e,f,g}, registered
module sequenciador_principal
  import pacote_principal::*;
#(
  parameter int DEB_CICLOS = 4,
  parameter int AUTO_DIV   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] p_in,
  input  logic       passo_req,
  input  logic       modo,
  output logic       passo_ack,
  output logic       ocupado,
  output logic [1:0] estado,
  output logic [6:0] seg
);

  localparam int CW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

  // Two-flop synchronizers for every asynchronous input.
  logic [3:0] p_meta_reg, p_sync_reg;
  logic       req_meta_reg, req_sync_reg;
  logic       modo_meta_reg, modo_sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_meta_reg    <= '0;
      p_sync_reg    <= '0;
      req_meta_reg  <= 1'b0;
      req_sync_reg  <= 1'b0;
      modo_meta_reg <= 1'b0;
      modo_sync_reg <= 1'b0;
    end else begin
      p_meta_reg    <= p_in;
      p_sync_reg    <= p_meta_reg;
      req_meta_reg  <= passo_req;
      req_sync_reg  <= req_meta_reg;
      modo_meta_reg <= modo;
      modo_sync_reg <= modo_meta_reg;
    end
  end

  logic [3:0] p_deb;

`ifdef SEQUENCIADOR_DEBOUNCE_EN
  localparam int DCW = $clog2(DEB_CICLOS);

  // A bit flips only after DEB_CICLOS consecutive cycles of disagreement;
  // one agreeing cycle clears the run.
  for (genvar gi = 0; gi < 4; gi++) begin : g_deb
    logic [DCW-1:0] cnt_reg;
    logic           deb_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
        deb_reg <= 1'b0;
      end else if (p_sync_reg[gi] == deb_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == DCW'(DEB_CICLOS - 1)) begin
        cnt_reg <= '0;
        deb_reg <= p_sync_reg[gi];
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign p_deb[gi] = deb_reg;
  end
`else
  assign p_deb = p_sync_reg;
`endif

  // Automatic step timebase; parked at 0 in manual mode.
  logic [CW-1:0] cnt_reg;
  logic          tick;

  assign tick = (cnt_reg == CW'(AUTO_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt_reg <= '0;
    else if (!modo_sync_reg) cnt_reg <= '0;
    else if (tick)           cnt_reg <= '0;
    else                     cnt_reg <= cnt_reg + 1'b1;
  end

  // Control FSM.
  estado_fsm_t state_reg, state_next;
  logic        manual_reg;
  logic [3:0]  p_reg;
  codigo_t     estado_reg, estado_next;
  logic [6:0]  seg_reg;

  logica_proximo_estado u_logica (
    .e (estado_reg),
    .p (p_reg),
    .y (estado_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= OCIOSO;
      manual_reg <= 1'b0;
      p_reg      <= '0;
      estado_reg <= 2'b00;
      seg_reg    <= SEG_00;
    end else begin
      state_reg <= state_next;
      // A request beats a coincident tick; the tick is simply lost.
      if (state_reg == OCIOSO && (req_sync_reg || tick))
        manual_reg <= req_sync_reg;
      if (state_reg == AMOSTRA)
        p_reg <= p_deb;
      if (state_reg == APLICA)
        estado_reg <= estado_next;
      seg_reg <= seg_de_codigo(estado_reg);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OCIOSO:   if (req_sync_reg || tick) state_next = AMOSTRA;
      AMOSTRA:  state_next = APLICA;
      APLICA:   state_next = manual_reg ? CONFIRMA : OCIOSO;
      CONFIRMA: if (!req_sync_reg) state_next = OCIOSO;
      default:  state_next = OCIOSO;
    endcase
  end

  always_comb begin
    passo_ack = (state_reg == CONFIRMA);
    ocupado   = (state_reg != OCIOSO);
  end

  assign estado = estado_reg;
  assign seg    = seg_reg;

endmodule

// File: tb/tb_sequenciador_principal.sv
module tb_sequenciador_principal;
  import pacote_principal::*;

  localparam int DEB = 4;
  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] p_in;
  logic       passo_req;
  logic       modo;
  logic       passo_ack;
  logic       ocupado;
  logic [1:0] estado;
  logic [6:0] seg;

  logic [1:0] f_e;
  logic [3:0] f_p;
  logic [1:0] f_y;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sequenciador_principal #(.DEB_CICLOS(DEB), .AUTO_DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_in      (p_in),
    .passo_req (passo_req),
    .modo      (modo),
    .passo_ack (passo_ack),
    .ocupado   (ocupado),
    .estado    (estado),
    .seg       (seg)
  );

  // Stand-alone copy of the next-code function for codes not reachable
  // through the sequencer from reset (e.g. 01).
  logica_proximo_estado u_ref (
    .e (f_e),
    .p (f_p),
    .y (f_y)
  );

  typedef struct {
    logic [1:0] e;
    logic [3:0] p;
    logic [1:0] y;
  } vec_f_t;

  typedef struct {
    logic [3:0] p;
    logic [1:0] est;
    logic [6:0] sg;
  } vec_passo_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic settle_p(input logic [3:0] v);
    p_in = v;
    repeat (DEB + 5) @(negedge clk);
  endtask

  task automatic pulso_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic passo_manual(output logic ok);
    int n;
    passo_req = 1'b1;
    n = 0;
    while (!passo_ack && n < 20) begin @(negedge clk); n++; end
    ok = passo_ack;
    passo_req = 1'b0;
    n = 0;
    while (passo_ack && n < 20) begin @(negedge clk); n++; end
  endtask

  vec_f_t     tab_f[8];
  vec_passo_t tab_p[6];

  initial begin
    logic ok;
    int   rises, ack_seen, n;
    int   t_rise[4];
    logic prev;

    tab_f[0] = '{2'b00, 4'b1000, 2'b11};
    tab_f[1] = '{2'b11, 4'b1111, 2'b11};
    tab_f[2] = '{2'b10, 4'b1100, 2'b10};
    tab_f[3] = '{2'b01, 4'b0110, 2'b11};
    tab_f[4] = '{2'b00, 4'b0000, 2'b00};
    tab_f[5] = '{2'b00, 4'b0101, 2'b10};
    tab_f[6] = '{2'b01, 4'b1000, 2'b01};
    tab_f[7] = '{2'b11, 4'b1100, 2'b10};

    tab_p[0] = '{4'b0000, 2'b00, SEG_00};
    tab_p[1] = '{4'b0101, 2'b10, SEG_10};
    tab_p[2] = '{4'b1100, 2'b10, SEG_10};
    tab_p[3] = '{4'b0111, 2'b11, SEG_11};
    tab_p[4] = '{4'b1111, 2'b11, SEG_11};
    tab_p[5] = '{4'b1100, 2'b10, SEG_10};

    rst_n = 1'b0; p_in = 4'b0000; passo_req = 1'b0; modo = 1'b0;
    f_e = 2'b00; f_p = 4'b0000;
    repeat (3) @(negedge clk);
    chk("reset_estado", 32'(estado), 32'h0);
    chk("reset_ack", 32'(passo_ack), 32'h0);
    chk("reset_ocupado", 32'(ocupado), 32'h0);
    chk("reset_seg", 32'(seg), 32'(SEG_00));
    rst_n = 1'b1;
    @(negedge clk);

    // Next-code function table.
    for (int i = 0; i < 8; i++) begin
      f_e = tab_f[i].e;
      f_p = tab_f[i].p;
      #1;
      chk($sformatf("func e=%b p=%b", tab_f[i].e, tab_f[i].p), 32'(f_y), 32'(tab_f[i].y));
    end

    // Manual step 00, p=1000: latency and handshake.
    settle_p(4'b1000);
    passo_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 4) begin
        chk("lat_k2_ocupado", 32'(ocupado), 32'h1);
        chk("lat_k2_ack", 32'(passo_ack), 32'h0);
        chk("lat_k2_estado", 32'(estado), 32'h0);
      end
      if (i == 5) begin
        chk("lat_k3_ack", 32'(passo_ack), 32'h1);
        chk("lat_k3_estado", 32'(estado), 32'h3);
        chk("lat_k3_seg_old", 32'(seg), 32'(SEG_00));
      end
      if (i == 6) chk("lat_k4_seg", 32'(seg), 32'(SEG_11));
    end
    repeat (3) @(negedge clk);
    chk("ack_held", 32'(passo_ack), 32'h1);
    passo_req = 1'b0;
    n = 0;
    while (passo_ack && n < 20) begin @(negedge clk); n++; end
    chk("ack_dropped", 32'(passo_ack), 32'h0);
    chk("idle_after", 32'(ocupado), 32'h0);

    // Table of consecutive manual steps from 00.
    pulso_reset();
    for (int i = 0; i < 6; i++) begin
      settle_p(tab_p[i].p);
      passo_manual(ok);
      chk($sformatf("step%0d_ack", i), 32'(ok), 32'h1);
      chk($sformatf("step%0d_estado", i), 32'(estado), 32'(tab_p[i].est));
      chk($sformatf("step%0d_seg", i), 32'(seg), 32'(tab_p[i].sg));
      chk($sformatf("step%0d_idle", i), 32'(ocupado), 32'h0);
    end

    // Reset during APLICA, request held through release.
    passo_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_abort_ocupado", 32'(ocupado), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_estado", 32'(estado), 32'h0);
    chk("abort_ack", 32'(passo_ack), 32'h0);
    chk("abort_seg", 32'(seg), 32'(SEG_00));
    chk("abort_ocupado", 32'(ocupado), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!passo_ack && n < 20) begin @(negedge clk); n++; end
    chk("rerequest_ack", 32'(passo_ack), 32'h1);
`ifdef SEQUENCIADOR_DEBOUNCE_EN
    chk("rerequest_estado", 32'(estado), 32'h0);
`else
    chk("rerequest_estado", 32'(estado), 32'h3);
`endif
    passo_req = 1'b0;
    n = 0;
    while (passo_ack && n < 20) begin @(negedge clk); n++; end

    // Automatic stepping: one step every DIV cycles, never acked.
    pulso_reset();
    settle_p(4'b1000);
    modo = 1'b1;
    rises = 0; ack_seen = 0; prev = ocupado; n = 0;
    while (rises < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (passo_ack) ack_seen++;
      if (ocupado && !prev) begin t_rise[rises] = n; rises++; end
      prev = ocupado;
    end
    chk("auto_rises", 32'(rises), 32'h4);
    for (int i = 1; i < 4; i++)
      if (i < rises) chk($sformatf("auto_period%0d", i), 32'(t_rise[i] - t_rise[i-1]), 32'(DIV));
    chk("auto_no_ack", 32'(ack_seen), 32'h0);
    chk("auto_estado", 32'(estado), 32'h3);

    // Manual request coinciding with a tick.
    n = 0;
    while (!(dut.cnt_reg == 3'(DIV - 3) && !ocupado) && n < 40) begin @(negedge clk); n++; end
    chk("coinc_sync_found", 32'(n < 40), 32'h1);
    passo_req = 1'b1;
    rises = 0; ack_seen = 0; prev = ocupado;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (ocupado && !prev) rises++;
      prev = ocupado;
      if (passo_ack) begin ack_seen = 1; passo_req = 1'b0; end
      if (i == 2) chk("coinc_tick_cnt", 32'(dut.cnt_reg), 32'(DIV - 1));
      if (i == 3) chk("coinc_cnt_zero", 32'(dut.cnt_reg), 32'h0);
    end
    chk("coinc_one_step", 32'(rises), 32'h1);
    chk("coinc_ack", 32'(ack_seen), 32'h1);
    passo_req = 1'b0;
    modo = 1'b0;
    repeat (6) @(negedge clk);
    chk("manual_cnt_held", 32'(dut.cnt_reg), 32'h0);

`ifdef SEQUENCIADOR_DEBOUNCE_EN
    // Debounce: 3-cycle p3 pulse ignored, 4 stable cycles accepted.
    settle_p(4'b0000);
    chk("deb_start", 32'(dut.p_deb), 32'h0);
    p_in = 4'b1000;
    repeat (3) @(negedge clk);
    p_in = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dut.p_deb[3] !== 1'b0) chk("deb_pulse_ignored", 32'(dut.p_deb[3]), 32'h0);
    end
    chk("deb_pulse_final", 32'(dut.p_deb[3]), 32'h0);
    p_in = 4'b1000;
    repeat (2 + DEB - 1) @(negedge clk);
    chk("deb_not_yet", 32'(dut.p_deb[3]), 32'h0);
    @(negedge clk);
    chk("deb_set", 32'(dut.p_deb[3]), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sequenciador_principal.md
SEQUENCIADOR_PRINCIPAL -- requirements
Module: sequenciador_principal

Interface
REQ-001 Parameter DEB_CICLOS, default 4: consecutive stable cycles a pushbutton bit needs before its debounced value updates (min 2).
REQ-002 Parameter AUTO_DIV, default 8: clock cycles between automatic steps (min 4).
REQ-003 clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 p_in  input  4  p3..p0 pushbuttons, asynchronous to clk.
REQ-006 passo_req  input  1  manual step request (level, 4-phase handshake), asynchronous.
REQ-007 modo  input  1  0 = manual stepping, 1 = automatic stepping; treated as quasi-static but synchronized.
REQ-008 passo_ack  output  1  manual step completed; held until passo_req is seen low.
REQ-009 ocupado  output  1  high whenever the FSM is not in OCIOSO.
REQ-010 estado  output  2  current code {e1,e0}.
REQ-011 seg  output  7  display {a,b,c,d,e,f,g}, registered.

Function
REQ-012 p_in, passo_req and modo SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 Next code: y1 = e1 | ~e0&p3 | p2&p1&~p0 | p2&p0&~p3; y0 = e1&~p3 | e1&~p2 | e1&p1&p0 | ~e1&e0 | ~e1&p3; p is the sampled debounced value.
REQ-014 FSM states: OCIOSO, AMOSTRA, APLICA, CONFIRMA; one transition per cycle except OCIOSO and CONFIRMA.
REQ-015 OCIOSO -> AMOSTRA on synchronized passo_req=1 (manual step) or auto tick (automatic step); otherwise stay.
REQ-016 AMOSTRA: capture debounced p into p_reg; -> APLICA.
REQ-017 APLICA: estado <= f(estado, p_reg); manual step -> CONFIRMA, automatic step -> OCIOSO.
REQ-018 CONFIRMA: passo_ack=1; -> OCIOSO when synchronized passo_req=0; new request impossible until then.
REQ-019 Latency: synchronized req seen in OCIOSO at cycle k -> estado new and passo_ack=1 visible at k+3; seg updated at k+4.
REQ-020 Auto counter counts 0..AUTO_DIV-1 and wraps only while synchronized modo=1; held at 0 when modo=0; tick = count equals AUTO_DIV-1.
REQ-021 Tick outside OCIOSO is dropped, not queued.
REQ-022 Manual request and tick in the same OCIOSO cycle: manual wins, tick dropped, counter restarts at 0.
REQ-023 seg patterns: 00->0001100, 01->1111010, 10->1111100, 11->1110011.
REQ-024 Identical next code still counts as a completed step (ack issued).

Reset
REQ-025 rst_n low SHALL immediately force: FSM OCIOSO, estado 00, p_reg 0000, debounced p 0000, synchronizers 0, counters 0, passo_ack 0, ocupado 0, seg 0001100.
REQ-026 Reset mid-step SHALL abort the step with no estado update; a request held through reset release is served as a new request.

Configuration
REQ-027 Macro SEQUENCIADOR_DEBOUNCE_EN defined: per-bit counter; a debounced bit changes only after its synchronized value differs from it for DEB_CICLOS consecutive cycles; any bounce restarts the count.
REQ-028 Macro undefined: debounced p equals synchronized p_in; DEB_CICLOS is ignored, no debounce counters are built.

Structure
REQ-029 Package pacote_principal: 2-bit code typedef, FSM state enum, four seg pattern constants.
REQ-030 Sub-module logica_proximo_estado: purely combinational REQ-013 function, ports e[1:0], p[3:0], y[1:0].

Verification
REQ-031 Reset, estado=00, p=1000, manual step -> estado 11 at k+3, seg 1110011 at k+4, ack high until req drops.
REQ-032 estado=11, p=1111 step -> 11 with ack; estado=10, p=1100 -> 10; estado=01, p=0110 -> 11; p=0000 from 00 -> 00.
REQ-033 modo=1, AUTO_DIV=8, p=1000 from 00 -> one step every 8 cycles, passo_ack stays 0.
REQ-034 Request and tick coincide -> exactly one step, ack=1, counter reads 0 next cycle.
REQ-035 DEBOUNCE_EN, DEB_CICLOS=4: p3 pulse of 3 cycles ignored; 4 stable cycles -> debounced p3 set.
REQ-036 rst_n low during APLICA -> estado 00, ack 0, seg 0001100 immediately.
